// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray<->binary converter among NREQ requesters.
// Optional statistics ports (conv_count, stall) are enabled with `define GRAY_CONV_ARB_STATS_EN.
module gray_conv_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_mode,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id
`ifdef GRAY_CONV_ARB_STATS_EN
  ,
  output logic [15:0]           conv_count,
  output logic                  stall
`endif
);

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   ptr_next;
  logic             win_found;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_mode;
  logic [WIDTH-1:0] conv_p0;

  // Stage p0: scan requesters starting at ptr and convert the winner's code
  always_comb begin : arb_scan
    int k;
    k         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!win_found && req_valid[k]) begin
        win_found = 1'b1;
        win_idx   = IDW'(k);
      end
    end
  end

  assign slot_free = !out_valid || out_ready;
  // Gating with rst_n keeps grants quiet while reset is held, even though the slot reads empty
  assign accept    = rst_n && slot_free && win_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  assign sel_data = req_data[int'(win_idx)*WIDTH +: WIDTH];
  assign sel_mode = req_mode[win_idx];
  assign conv_p0  = sel_mode ? bin_to_gray(sel_data) : gray_to_bin(sel_data);
  assign ptr_next = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

  // Stage p1: output slot; a drain and a new accept on the same edge leave no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= conv_p0;
      out_id    <= win_idx;
      ptr       <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GRAY_CONV_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_count <= '0;
      stall      <= 1'b0;
    end else begin
      stall <= out_valid && !out_ready;
      if (out_valid && out_ready && (conv_count != 16'hFFFF)) begin
        conv_count <= conv_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: a cycle-level reference model predicts grants and
// results; a separate monitor pops expected results whenever the output slot transfers.
module tb_gray_conv_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_mode;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
`ifdef GRAY_CONV_ARB_STATS_EN
  logic [15:0]           conv_count;
  logic                  stall;
`endif

  always #5 clk = ~clk;

  gray_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
`ifdef GRAY_CONV_ARB_STATS_EN
    ,
    .conv_count(conv_count),
    .stall     (stall)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Pending request per requester (held until the model sees it granted)
  logic             pend_valid[NREQ];
  logic [WIDTH-1:0] pend_data[NREQ];
  logic             pend_mode[NREQ];
  logic             rdy_drv;

  // Reference model state
  int m_ptr;
  bit m_full;
  bit m_stall;
  int m_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gray->binary: bit i is the parity of all Gray bits at or above i
  function automatic logic [WIDTH-1:0] ref_conv(input logic [WIDTH-1:0] d, input logic m);
    logic [WIDTH-1:0] r;
    r = '0;
    if (m) r = d ^ (d >> 1);
    else for (int i = 0; i < WIDTH; i++) r[i] = ^(d >> i);
    return r;
  endfunction

  task automatic set_req(input int k, input logic [WIDTH-1:0] d, input logic m);
    pend_valid[k] = 1'b1;
    pend_data[k]  = d;
    pend_mode[k]  = m;
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_ptr = 0; m_full = 1'b0; m_stall = 1'b0; m_count = 0;
    for (int k = 0; k < NREQ; k++) pend_valid[k] = 1'b0;
  endtask

  // One clock cycle: drive at negedge+1, check and advance the model at negedge+2
  task automatic cycle();
    int win;
    int k;
    logic [NREQ-1:0] exp_ready;
    bit slot_free;
    @(negedge clk);
    #1;
    for (int j = 0; j < NREQ; j++) begin
      req_valid[j]                 = pend_valid[j];
      req_data[j*WIDTH +: WIDTH]   = pend_valid[j] ? pend_data[j] : WIDTH'($urandom);
      req_mode[j]                  = pend_valid[j] ? pend_mode[j] : 1'($urandom);
    end
    out_ready = rdy_drv;
    #1;
    chk("out_valid", out_valid, m_full);
`ifdef GRAY_CONV_ARB_STATS_EN
    chk("stall", stall, m_stall);
    chk("conv_count", conv_count, m_count);
`endif
    slot_free = !m_full || rdy_drv;
    win = -1;
    for (int i = 0; i < NREQ; i++) begin
      k = (m_ptr + i) % NREQ;
      if (win < 0 && pend_valid[k]) win = k;
    end
    exp_ready = '0;
    if (slot_free && win >= 0) exp_ready[win] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    m_stall = m_full && !rdy_drv;
    if (m_full && rdy_drv && m_count < 65535) m_count++;
    if (slot_free && win >= 0) begin
      exp_q.push_back(int'(ref_conv(pend_data[win], pend_mode[win])) | (win << WIDTH));
      m_ptr = (win + 1) % NREQ;
      pend_valid[win] = 1'b0;
      m_full = 1'b1;
    end else if (rdy_drv) begin
      m_full = 1'b0;
    end
  endtask

  // Monitor: a transfer happens at the next edge when out_valid && out_ready now
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexpected", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e & ((1 << WIDTH) - 1));
          chk("out_id", out_id, e >> WIDTH);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    req_mode  = '0;
    out_ready = 1'b1;
    rdy_drv   = 1'b1;
    clear_model();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_id", out_id, '0);
    chk("rst_req_ready", req_ready, '0);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Gray->binary sweep on requester 0
    for (int g = 0; g < (1 << WIDTH); g++) begin
      set_req(0, WIDTH'(g), 1'b0);
      cycle();
    end
    cycle();

    // Binary->Gray on requester 2
    set_req(2, 4'b1011, 1'b1);
    cycle();
    cycle();
    chk("b2g_data", out_data, 4'b1110);
    chk("b2g_id", out_id, 2);

    // Round-robin with all requesters continuously valid
    for (int c = 0; c < 4 * NREQ; c++) begin
      for (int k = 0; k < NREQ; k++)
        if (!pend_valid[k]) set_req(k, WIDTH'($urandom), 1'($urandom));
      cycle();
    end
    repeat (NREQ) cycle();

    // Backpressure: slot frozen, no grants, then drain and accept on the same edge
    set_req(1, 4'b1000, 1'b0);
    cycle();
    rdy_drv = 1'b0;
    set_req(3, WIDTH'($urandom), 1'($urandom));
    repeat (5) begin
      cycle();
      chk("bp_data", out_data, 4'b1111);
      chk("bp_id", out_id, 1);
    end
    rdy_drv = 1'b1;
    cycle();
    cycle();
    chk("bp_next_id", out_id, 3);

    // Asynchronous reset while a result is held
    set_req(2, WIDTH'($urandom), 1'b0);
    cycle();
    rdy_drv = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, '0);
    chk("mid_rst_out_id", out_id, '0);
    chk("mid_rst_req_ready", req_ready, '0);
    clear_model();
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    rdy_drv = 1'b1;
    set_req(1, WIDTH'($urandom), 1'($urandom));
    set_req(3, WIDTH'($urandom), 1'($urandom));
    cycle();
    cycle();
    chk("post_rst_id", out_id, 1);
    cycle();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++)
        if (!pend_valid[k] && $urandom_range(0, 2) == 0)
          set_req(k, WIDTH'($urandom), 1'($urandom));
      rdy_drv = ($urandom_range(0, 3) != 0);
      cycle();
    end
    for (int k = 0; k < NREQ; k++) pend_valid[k] = pend_valid[k];
    rdy_drv = 1'b1;
    repeat (NREQ + 3) cycle();
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

- Shares one registered Gray/binary code converter among NREQ requesters.
- Uses a round-robin arbiter with valid/ready handshakes on both sides.
- Each requester submits a WIDTH-bit code plus a direction bit.
- The block returns the converted code tagged with the requester index through a single buffered output slot.
- It sits between the code-generating blocks (counters, encoders) and the consumers that need binary or Gray form.

## Interface
Parameters:
- WIDTH, 4, code width in bits (≥2)
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of out_id (derived, do not override)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_data  input  NREQ*WIDTH  requester k code at [k*WIDTH +: WIDTH]
- req_mode  input  NREQ  per-requester direction: 0 = Gray→binary, 1 = binary→Gray
- req_ready  output  NREQ  one-hot grant; requester k's data is accepted in a cycle where req_valid[k] && req_ready[k]
- out_valid  output  1  output slot holds a converted result
- out_ready  input  1  consumer accepts the result when out_valid && out_ready
- out_data  output  WIDTH  converted code
- out_id  output  IDW  index of the requester that produced out_data

## Operation
- Gray→binary conversion:
  - b[WIDTH-1] = g[WIDTH-1]
  - b[i] = g[i] ^ b[i+1], for i from WIDTH-2 down to 0
- Binary→Gray conversion: g = b ^ (b >> 1).
- Output slot: one register set {out_valid, out_data, out_id}.
- slot_free = !out_valid || out_ready.
- Arbitration:
  - Round-robin pointer ptr, range 0..NREQ-1.
  - The winner is the first k with req_valid[k], scanning ptr, ptr+1, … modulo NREQ.
  - req_ready is one-hot at the winner only when slot_free and any req_valid is high; otherwise it is all zero.
  - req_ready is combinational from req_valid, ptr, out_valid and out_ready.
- On accept of requester k:
  - the slot loads the converted req_data[k] (per req_mode[k]), out_id = k, out_valid = 1
  - ptr becomes (k+1) mod NREQ
- If the slot is drained (out_valid && out_ready) with no accept, out_valid goes to 0.
- Simultaneous drain and accept: the new result replaces the old one in the same edge; no bubble.
- If no accept happens, ptr holds. Requesters not granted simply wait; the block never drops a valid request.
- Requesters must hold req_valid/req_data/req_mode stable until accepted. The block does not check this.
- Reset (asynchronous, any time including mid-transfer):
  - out_valid = 0, out_data = 0, out_id = 0, ptr = 0
  - req_ready goes to 0 while rst_n is low
  - a pending result is discarded
- Starvation bound: a continuously valid requester is granted within NREQ accepts.

## Timing
- Latency: accept at rising edge N → out_valid/out_data/out_id valid after edge N.
- Peak throughput: one conversion per cycle with out_ready held high.
- Backpressure:
  - With out_ready low and out_valid high, req_ready = 0 and the slot contents stay frozen.
  - When out_ready rises, an accept and a drain occur on the same edge.
- First grant after reset release: the lowest-index valid requester, because ptr = 0.

## Configuration
- Macro GRAY_CONV_ARB_STATS_EN.
- Defined:
  - adds output port conv_count (16 bits), the number of completed output transfers (out_valid && out_ready)
  - conv_count saturates at 16'hFFFF and resets to 0 with rst_n
  - adds output port stall (1 bit), registered, high for the cycle after any cycle with out_valid && !out_ready
- Not defined: both ports and their logic are absent; the remaining behaviour is identical.

## Test plan
- Reset and Gray→binary sweep:
  - stimulus: reset, then requester 0 only, mode 0, Gray 0000..1111 with out_ready = 1
  - required: out_data = 0000,0001,0011,0010,0111,0110,0100,0101,1111,1110,1100,1101,1000,1001,1011,1010; out_id = 0; one result per cycle
- Binary→Gray:
  - stimulus: requester 2, mode 1, data 1011
  - required: one cycle later out_data = 1110, out_id = 2
- Round-robin:
  - stimulus: all four requesters valid continuously, out_ready = 1
  - required: out_id sequence 0,1,2,3,0,1…; each req_ready asserts exactly once per 4 cycles
- Backpressure:
  - stimulus: requester 1 sends Gray 1000, then out_ready is held 0 for 5 cycles while requester 3 is valid
  - required: out_data stays 1111 and out_id stays 1; req_ready stays 0000; on out_ready = 1, requester 3 is accepted on the same edge as the drain
- Mid-operation reset:
  - stimulus: assert rst_n = 0 asynchronously while out_valid = 1
  - required: out_valid, out_data and out_id go to 0 immediately; after release, the lowest valid requester wins
- With GRAY_CONV_ARB_STATS_EN:
  - stimulus: 10 transfers, including 3 stall cycles
  - required: conv_count = 10 and stall pulses 3 times
